sipo_frame_receiver: RTL and testbench

//   Receiving end of the single-wire serial bit stream driven by the team's shift-register

---
 rtl/sipo_rx_pkg.sv | 21 ++
 rtl/sipo_shift_core.sv | 38 +++
 rtl/sipo_frame_receiver.sv | 183 ++++++++++++++++++
 tb/tb_sipo_frame_receiver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial-in / parallel-out frame receiver.
// Contents:
//   rx_state_e      receiver FSM states
//   DATA_W_DEFAULT  default number of data bits per frame
//   cnt_width()     bit-counter width able to hold 0..DATA_W
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } rx_state_e;

    localparam int unsigned DATA_W_DEFAULT = 8;

    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// DATA_W-bit MSB-first shift register with a bit counter.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         zero the register and the counter (start of frame)
//   shift_en      shift bit_in into the LSB and increment the counter
//   bit_in        serial data bit
//   shreg         shift register contents
//   count         number of bits shifted since the last clear
module sipo_shift_core
    import sipo_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    localparam int unsigned CNT_W = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] shreg,
    output logic [CNT_W-1:0]  count
);

    // Clearing also wipes stale bits so an aborted frame leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            shreg <= '0;
            count <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[DATA_W-2:0], bit_in};
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits MSB-first, optional
// even-parity bit, then the word is offered on a valid/ready parallel port.
// Build option: define RX_PARITY_EN to expect a parity bit and expose parity_err.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   serial_in     serial line (idles low)
//   serial_en     bit strobe; serial_in is sampled only when high
//   data_out      received word, held while out_valid
//   out_valid     word available
//   out_ready     consumer accepts the word on out_valid & out_ready
//   busy          frame in progress
//   overflow      sticky: a completed word was dropped
//   ovf_clr       synchronous clear of the sticky flags
//   parity_err    sticky parity failure (RX_PARITY_EN only)
module sipo_frame_receiver
    import sipo_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              serial_in,
    input  logic              serial_en,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow,
    input  logic              ovf_clr
`ifdef RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);

    rx_state_e          state;
    rx_state_e          state_next;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   count;
    logic               slot_free_c;
    logic               clear_c;
    logic               shift_c;
    logic               load_c;
    logic               drop_c;
`ifdef RX_PARITY_EN
    logic               par_bad;
    logic               par_sample_c;
    logic               par_fail_c;
`endif

    // Output slot can take a word if empty or being drained this cycle.
    assign slot_free_c = !out_valid || out_ready;

    sipo_shift_core #(
        .DATA_W (DATA_W)
    ) u_shift_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear_c),
        .shift_en (shift_c),
        .bit_in   (serial_in),
        .shreg    (shreg),
        .count    (count)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_next   = state;
        clear_c      = 1'b0;
        shift_c      = 1'b0;
        load_c       = 1'b0;
        drop_c       = 1'b0;
`ifdef RX_PARITY_EN
        par_sample_c = 1'b0;
        par_fail_c   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (serial_en && serial_in) begin
                    state_next = SHIFT;
                    clear_c    = 1'b1;
                end
            end
            SHIFT: begin
                if (serial_en) begin
                    shift_c = 1'b1;
                    // The edge sampling the last data bit also leaves SHIFT.
                    if (count == CNT_W'(DATA_W - 1)) begin
`ifdef RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = COMMIT;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef RX_PARITY_EN
                if (serial_en) begin
                    par_sample_c = 1'b1;
                    state_next   = COMMIT;
                end
`else
                state_next = IDLE;
`endif
            end
            COMMIT: begin
                state_next = IDLE;
`ifdef RX_PARITY_EN
                if (par_bad) begin
                    par_fail_c = 1'b1;
                end else
`endif
                if (slot_free_c) begin
                    load_c = 1'b1;
                end else begin
                    drop_c = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef RX_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even number of ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad <= 1'b0;
        end else if (clear_c) begin
            par_bad <= 1'b0;
        end else if (par_sample_c) begin
            par_bad <= (^shreg) ^ serial_in;
        end
    end
`endif

    // Output port, handshake and sticky flags; a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            busy <= (state_next != IDLE);
            if (load_c) begin
                data_out  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
`ifdef RX_PARITY_EN
            if (par_fail_c) begin
                parity_err <= 1'b1;
            end else if (ovf_clr) begin
                parity_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Self-checking bench for sipo_frame_receiver: directed frames plus randomized
// line/strobe/handshake activity, compared every cycle against a frame-level model.
module tb_sipo_frame_receiver;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          serial_in;
    logic          serial_en;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic          ovf_clr;
`ifdef RX_PARITY_EN
    logic          parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sipo_frame_receiver #(
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .serial_en  (serial_en),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // Frame-level reference: phase 0 idle, 1 collecting bits, 4 awaiting parity,
    // 2 word complete (handed over on the next edge).
    int          m_phase;
    int          m_nbits;
    int unsigned m_word;
    int unsigned m_data;
    bit          m_valid;
    bit          m_ovf;
    bit          m_pbad;
    bit          m_perr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_nbits = 0;
        m_word  = 0;
        m_data  = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_pbad  = 1'b0;
        m_perr  = 1'b0;
    endtask

    // One clock edge of the reference, using the inputs present before the edge.
    task automatic model_step();
        bit hand_over;
        bit loaded;
        bit set_ovf;
        bit set_perr;
        hand_over = (m_phase == 2);
        loaded    = hand_over && !m_pbad && (!m_valid || out_ready);
        set_ovf   = hand_over && !m_pbad && m_valid && !out_ready;
        set_perr  = hand_over && m_pbad;
        if (loaded) begin
            m_data  = m_word;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        m_ovf  = set_ovf  ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_perr = set_perr ? 1'b1 : (ovf_clr ? 1'b0 : m_perr);
        case (m_phase)
            0: if (serial_en && serial_in) begin
                m_phase = 1;
                m_nbits = 0;
                m_word  = 0;
                m_pbad  = 1'b0;
            end
            1: if (serial_en) begin
                m_word  = m_word * 2 + 32'(serial_in);
                m_nbits = m_nbits + 1;
                if (m_nbits == int'(DW)) begin
`ifdef RX_PARITY_EN
                    m_phase = 4;
`else
                    m_phase = 2;
`endif
                end
            end
            4: if (serial_en) begin
                m_pbad  = (($countones(m_word) + int'(serial_in)) % 2) != 0;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        check_eq({tag, "_data"},  32'(data_out),  m_data);
        check_eq({tag, "_busy"},  32'(busy),      32'(m_phase != 0));
        check_eq({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
`ifdef RX_PARITY_EN
        check_eq({tag, "_perr"},  32'(parity_err), 32'(m_perr));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #2;
        compare_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        serial_en = 1'b1;
        serial_in = 1'b0;
        repeat (n) tick(tag);
    endtask

    // Start bit then the word MSB-first; 'gap' unstrobed cycles before each data bit.
    task automatic send_frame(input logic [DW-1:0] w, input int gap, input string tag);
        serial_en = 1'b1;
        serial_in = 1'b1;
        tick(tag);
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            repeat (gap) begin
                serial_en = 1'b0;
                serial_in = 1'($urandom);
                tick(tag);
            end
            serial_en = 1'b1;
            serial_in = w[i];
            tick(tag);
        end
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w;
        reset_n   = 1'b0;
        serial_in = 1'b0;
        serial_en = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_data",  32'(data_out),  32'd0);
        check_eq("reset_busy",  32'(busy),      32'd0);
        check_eq("reset_ovf",   32'(overflow),  32'd0);
        reset_n = 1'b1;
        idle(2, "pre");

`ifndef RX_PARITY_EN
        // Back-to-back strobes, consumer always ready.
        out_ready = 1'b1;
        send_frame(8'hA5, 0, "t1");
        check_eq("t1_lastbit_valid", 32'(out_valid), 32'd0);
        idle(1, "t1");
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_data",  32'(data_out),  32'h0000_00A5);
        idle(1, "t1");
        check_eq("t1_valid_one_cycle", 32'(out_valid), 32'd0);

        // Consumer stalled: the second word is dropped.
        out_ready = 1'b0;
        send_frame(8'h3C, 0, "t2");
        idle(3, "t2");
        send_frame(8'hC3, 0, "t2");
        idle(3, "t2");
        check_eq("t2_data", 32'(data_out), 32'h0000_003C);
        check_eq("t2_ovf",  32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick("t2");
        ovf_clr = 1'b0;
        check_eq("t2_ovf_clr", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        idle(1, "t2");
        check_eq("t2_drained", 32'(out_valid), 32'd0);

        // New word loads on the very edge the pending one is accepted.
        out_ready = 1'b0;
        send_frame(8'h11, 0, "t3");
        idle(3, "t3");
        send_frame(8'h22, 0, "t3");
        out_ready = 1'b1;
        idle(1, "t3");
        check_eq("t3_valid", 32'(out_valid), 32'd1);
        check_eq("t3_data",  32'(data_out),  32'h0000_0022);
        check_eq("t3_ovf",   32'(overflow),  32'd0);
        idle(1, "t3");
        check_eq("t3_drained", 32'(out_valid), 32'd0);

        // Sparse strobes; then a high line without strobe must not start a frame.
        send_frame(8'h5A, 2, "t4");
        idle(1, "t4");
        check_eq("t4_data", 32'(data_out), 32'h0000_005A);
        idle(1, "t4");
        serial_en = 1'b0;
        serial_in = 1'b1;
        repeat (5) tick("t4");
        check_eq("t4_no_start", 32'(busy), 32'd0);

        // Reset in the middle of a frame.
        serial_en = 1'b1;
        serial_in = 1'b1;
        tick("t5");
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'($urandom);
            tick("t5");
        end
        check_eq("t5_busy_mid", 32'(busy), 32'd1);
        do_reset("t5_rst");
        send_frame(8'h81, 0, "t5");
        idle(1, "t5");
        check_eq("t5_data", 32'(data_out), 32'h0000_0081);
        idle(1, "t5");
`else
        // Good and bad parity.
        out_ready = 1'b1;
        send_frame(8'hF0, 0, "t6");
        serial_in = 1'b0;
        tick("t6");
        idle(1, "t6");
        check_eq("t6_good_valid", 32'(out_valid), 32'd1);
        check_eq("t6_good_data",  32'(data_out),  32'h0000_00F0);
        check_eq("t6_good_perr",  32'(parity_err), 32'd0);
        idle(1, "t6");
        send_frame(8'hF1, 0, "t6");
        serial_in = 1'b0;
        tick("t6");
        idle(1, "t6");
        check_eq("t6_bad_valid", 32'(out_valid), 32'd0);
        check_eq("t6_bad_perr",  32'(parity_err), 32'd1);
        ovf_clr = 1'b1;
        tick("t6");
        ovf_clr = 1'b0;
        check_eq("t6_perr_clr", 32'(parity_err), 32'd0);
`endif

        // Structured random frames with random gaps and consumer behaviour.
        for (int f = 0; f < 60; f++) begin
            w         = DW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            send_frame(w, int'($urandom_range(0, 2)), "rfrm");
`ifdef RX_PARITY_EN
            serial_en = 1'b1;
            serial_in = 1'($urandom);
            tick("rfrm");
`endif
            idle(int'($urandom_range(1, 3)), "rfrm");
        end

        // Unstructured random line, strobe, handshake and clear activity.
        for (int c = 0; c < 3000; c++) begin
            serial_en = ($urandom_range(0, 3) != 0);
            serial_in = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            tick("rnd");
        end
        ovf_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
